fft_load_sequencer: RTL and testbench
=====================================

FFT_LOAD_SEQUENCER -- requirements
Module: fft_load_sequencer

Interface
REQ-001 SHALL have parameter N_POINTS, default 64, FFT length in samples; power of two, at least 4.
REQ-002 SHALL have parameter SAMPLE_W, default 16, bits per real or imaginary component.
REQ-003 SHALL have parameter COMPLEX_IN, default 0, 0 = real-only frame, 1 = interleaved {re,im} frame.
REQ-004 SHALL have parameter BIT_REVERSE, default 0, 1 = fft_addr issued in bit-reversed order.
REQ-005 SHALL have derived FRAME_W = N_POINTS*SAMPLE_W*(1+COMPLEX_IN) and AW = $clog2(N_POINTS).
REQ-006 clk  input  1  sole clock, all state on posedge.
REQ-007 reset  input  1  synchronous, active-low reset.
REQ-008 frame_in  input  FRAME_W  sample frame from SPI; sample 0 in MSBs.
REQ-009 frame_valid  input  1  frame_in holds a complete frame.
REQ-010 frame_ready  output  1  block accepts a frame this cycle.
REQ-011 fft_hold  input  1  FFT core cannot take a write this cycle.
REQ-012 fft_done  input  1  FFT core finished; one-cycle pulse or level.
REQ-013 fft_wd  output  2*SAMPLE_W  write data {re,im} to the FFT core.
REQ-014 fft_addr  output  AW  write address to the FFT core.
REQ-015 fft_load  output  1  fft_wd/fft_addr valid this cycle.
REQ-016 fft_start  output  1  one-cycle start pulse.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement the states IDLE, LOAD, START and WAIT_DONE.
REQ-019 frame_ready SHALL be 1 only in IDLE; a frame SHALL be captured when frame_valid && frame_ready, and the state SHALL then move to LOAD.
REQ-020 In LOAD with fft_hold=0: fft_load=1, fft_wd = current sample, fft_addr = cnt (or bitrev(cnt) when BIT_REVERSE=1), cnt increments, shift register advances one sample.
REQ-021 In LOAD with fft_hold=1: fft_load=0; cnt and shift register held; fft_wd and fft_addr still reflect the pending sample.
REQ-022 Real mode: fft_wd = {sample, SAMPLE_W'b0}; complex mode: fft_wd = the 2*SAMPLE_W slice {re,im}.
REQ-023 After the load with cnt == N_POINTS-1, the next state SHALL be START; cnt wraps to 0.
REQ-024 START SHALL assert fft_start for exactly one cycle, then move to WAIT_DONE.
REQ-025 WAIT_DONE SHALL return to IDLE on fft_done=1; fft_done in IDLE, LOAD or START SHALL be ignored.
REQ-026 Latency: frame accepted at cycle k gives first fft_load at k+1 and fft_start at k+N_POINTS+1 plus one cycle per held cycle.
REQ-027 frame_in changes after capture SHALL not affect the frame in flight.
REQ-028 fft_load and fft_start SHALL never be high in the same cycle.

Reset
REQ-029 reset=0 at a clock edge SHALL force IDLE, cnt=0 and shift register 0, from any state including mid-LOAD.
REQ-030 During reset, outputs SHALL be: frame_ready=0, fft_load=0, fft_start=0, busy=0, fft_wd=0, fft_addr=0.
REQ-031 frame_ready=1 from the first cycle after reset returns high.

Structure
REQ-032 Package fft_pkg SHALL hold the state enum typedef and the default N_POINTS and SAMPLE_W constants.
REQ-033 Sub-module bit_reverse, parametrised by AW, SHALL provide the purely combinational address reversal.

Verification
REQ-034 N=64, real mode: frame of samples i -> 16'(i+1), valid at cycle 0 -> 64 loads, addr 0..63, fft_wd = {i+1, 16'h0}; fft_start at cycle 65.
REQ-035 BIT_REVERSE=1, N=8: addr sequence 0,4,2,6,1,5,3,7; data stays in frame order.
REQ-036 COMPLEX_IN=1, sample 0 = {16'h1234, 16'hABCD} -> first fft_wd = 32'h1234ABCD.
REQ-037 fft_hold high for 3 cycles at load 10 -> no fft_load for those cycles, addr 10 repeated with the same data, fft_start delayed by 3.
REQ-038 reset=0 at load 20 -> next cycle IDLE, all outputs 0, frame_ready=1 after release; a new frame restarts at addr 0.
REQ-039 frame_valid held high through WAIT_DONE -> frame_ready=0 and no capture until fft_done, then capture the next cycle; early fft_done during LOAD is ignored.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and default sizing for the FFT load sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned N_POINTS_DEF = 64;
  localparam int unsigned SAMPLE_W_DEF = 16;

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit reversal of an FFT write address.
module bit_reverse #(
  parameter int unsigned AW = 6
) (
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] rev
);

  always_comb begin
    rev = '0;
    for (int unsigned i = 0; i < AW; i++) begin
      rev[i] = addr[AW-1-i];
    end
  end

endmodule

// File: rtl/fft_load_sequencer.sv
// Captures a complete sample frame and streams it sample by sample into an
// FFT core, then pulses start and waits for the core to finish.
module fft_load_sequencer
  import fft_pkg::*;
#(
  parameter  int unsigned N_POINTS    = N_POINTS_DEF,
  parameter  int unsigned SAMPLE_W    = SAMPLE_W_DEF,
  parameter  int unsigned COMPLEX_IN  = 0,
  parameter  int unsigned BIT_REVERSE = 0,
  localparam int unsigned FRAME_W     = N_POINTS * SAMPLE_W * (1 + COMPLEX_IN),
  localparam int unsigned AW          = $clog2(N_POINTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_W-1:0]    frame_in,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic                  fft_hold,
  input  logic                  fft_done,
  output logic [2*SAMPLE_W-1:0] fft_wd,
  output logic [AW-1:0]         fft_addr,
  output logic                  fft_load,
  output logic                  fft_start,
  output logic                  busy
);

  localparam int unsigned   STEP = SAMPLE_W * (1 + COMPLEX_IN);
  localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

  state_t             state;
  logic [AW-1:0]      cnt;
  logic [AW-1:0]      rev;
  logic [FRAME_W-1:0] sreg;
  logic [STEP-1:0]    cur;

  // Sequencer: ready is a flop so it stays low while reset is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      frame_ready <= 1'b0;
    end else begin
      frame_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_valid && frame_ready) begin
            sreg  <= frame_in;
            cnt   <= '0;
            state <= LOAD;
          end else begin
            frame_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (!fft_hold) begin
            sreg <= {sreg[FRAME_W-STEP-1:0], STEP'(0)};
            cnt  <= cnt + AW'(1);
            if (cnt == LAST) begin
              state <= START;
            end
          end
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (fft_done) begin
            state       <= IDLE;
            frame_ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sample 0 sits in the MSBs; the frame shifts up one sample per load.
  assign cur = sreg[FRAME_W-1 -: STEP];

  generate
    if (COMPLEX_IN != 0) begin : g_complex
      assign fft_wd = cur;
    end else begin : g_real
      assign fft_wd = {cur, SAMPLE_W'(0)};
    end
  endgenerate

  bit_reverse #(
    .AW (AW)
  ) u_bit_reverse (
    .addr (cnt),
    .rev  (rev)
  );

  // Hold must gate the strobe in the same cycle, so load decodes live state.
  assign fft_addr  = (BIT_REVERSE != 0) ? rev : cnt;
  assign fft_load  = (state == LOAD) && !fft_hold;
  assign fft_start = (state == START);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fft_load_sequencer.sv
// Directed and randomized checks of fft_load_sequencer against a frame-level model.
module tb_fft_load_sequencer;

  localparam int unsigned NA  = 64;
  localparam int unsigned NB  = 8;
  localparam int unsigned SW  = 16;
  localparam int unsigned FWA = NA * SW;
  localparam int unsigned FWB = NB * SW * 2;

  logic clk;
  logic reset;
  logic fft_hold, fft_done;
  logic va, vb;
  logic [FWA-1:0] fa;
  logic [FWB-1:0] fb;
  logic rdy_a, rdy_b, load_a, load_b, start_a, start_b, busy_a, busy_b;
  logic [31:0] wd_a, wd_b;
  logic [5:0] addr_a;
  logic [2:0] addr_b;

  logic sel;
  logic m_rdy, m_load, m_start, m_busy;
  logic [31:0] m_wd;
  logic [5:0] m_addr;

  int total = 0;
  int bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_load_sequencer u_dut_a (
    .clk (clk), .reset (reset), .frame_in (fa), .frame_valid (va),
    .frame_ready (rdy_a), .fft_hold (fft_hold), .fft_done (fft_done),
    .fft_wd (wd_a), .fft_addr (addr_a), .fft_load (load_a),
    .fft_start (start_a), .busy (busy_a)
  );

  fft_load_sequencer #(
    .N_POINTS (NB), .SAMPLE_W (SW), .COMPLEX_IN (1), .BIT_REVERSE (1)
  ) u_dut_b (
    .clk (clk), .reset (reset), .frame_in (fb), .frame_valid (vb),
    .frame_ready (rdy_b), .fft_hold (fft_hold), .fft_done (fft_done),
    .fft_wd (wd_b), .fft_addr (addr_b), .fft_load (load_b),
    .fft_start (start_b), .busy (busy_b)
  );

  always_comb begin
    m_rdy   = sel ? rdy_b   : rdy_a;
    m_load  = sel ? load_b  : load_a;
    m_start = sel ? start_b : start_a;
    m_busy  = sel ? busy_b  : busy_a;
    m_wd    = sel ? wd_b    : wd_a;
    m_addr  = sel ? {3'b000, addr_b} : addr_a;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev_addr(input int v, input int bits);
    int r = 0;
    for (int k = 0; k < bits; k++) begin
      if (((v >> k) & 1) == 1) r += 1 << (bits - 1 - k);
    end
    return r;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 64'(m_rdy), 64'(0));
    chk({tag, "_load"},  64'(m_load), 64'(0));
    chk({tag, "_start"}, 64'(m_start), 64'(0));
    chk({tag, "_busy"},  64'(m_busy), 64'(0));
    chk({tag, "_wd"},    64'(m_wd), 64'(0));
    chk({tag, "_addr"},  64'(m_addr), 64'(0));
  endtask

  // One frame: pat 1 = directed sample values, abort_at >= 0 resets mid-load.
  task automatic run_frame(input bit b, input int pat, input int hold_at, input int hold_len,
                           input int done_dly, input bit keep_valid, input int abort_at);
    int n;
    int j;
    int held;
    bit hold;
    logic [31:0] ew [64];
    n = b ? int'(NB) : int'(NA);
    for (int i = 0; i < n; i++) begin
      logic [15:0] re, im;
      re = (pat == 1) ? 16'(i + 1) : 16'($urandom);
      im = 16'($urandom);
      if (b && pat == 1 && i == 0) begin
        re = 16'h1234;
        im = 16'hABCD;
      end
      if (b) begin
        fb[FWB-1-32*i -: 32] = {re, im};
        ew[i] = {re, im};
      end else begin
        fa[FWA-1-16*i -: 16] = re;
        ew[i] = {re, 16'h0000};
      end
    end
    sel = b;
    @(negedge clk);
    fft_hold = 1'b0;
    fft_done = 1'b0;
    if (b) vb = 1'b1; else va = 1'b1;
    #1;
    chk("idle_ready", 64'(m_rdy), 64'(1));
    chk("idle_busy", 64'(m_busy), 64'(0));
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      va = 1'b0;
      vb = 1'b0;
    end
    fa = {32{$urandom}};
    fb = {8{$urandom}};
    j = 0;
    held = 0;
    while (j < n) begin
      @(negedge clk);
      if (j == abort_at) begin
        reset = 1'b0;
        fft_hold = 1'b0;
        fft_done = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_quiet("rst_mid");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        return;
      end
      hold = (j == hold_at) && (held < hold_len);
      fft_hold = hold;
      fft_done = 1'($urandom);
      #1;
      chk("load_strobe", 64'(m_load), 64'(!hold));
      chk("load_addr", 64'(m_addr), 64'(b ? rev_addr(j, 3) : j));
      chk("load_wd", 64'(m_wd), 64'(ew[j]));
      chk("load_busy", 64'(m_busy), 64'(1));
      chk("load_start", 64'(m_start), 64'(0));
      chk("load_ready", 64'(m_rdy), 64'(0));
      @(posedge clk);
      if (hold) held++; else j++;
    end
    @(negedge clk);
    fft_hold = 1'($urandom);
    fft_done = 1'($urandom);
    #1;
    chk("start_pulse", 64'(m_start), 64'(1));
    chk("start_load", 64'(m_load), 64'(0));
    chk("start_busy", 64'(m_busy), 64'(1));
    @(posedge clk);
    for (int d = 0; d <= done_dly; d++) begin
      @(negedge clk);
      fft_hold = 1'b0;
      fft_done = (d == done_dly);
      #1;
      chk("wait_busy", 64'(m_busy), 64'(1));
      chk("wait_start", 64'(m_start), 64'(0));
      chk("wait_load", 64'(m_load), 64'(0));
      chk("wait_ready", 64'(m_rdy), 64'(0));
      @(posedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    va = 1'b0;
    vb = 1'b0;
    fa = '0;
    fb = '0;
    fft_hold = 1'b0;
    fft_done = 1'b0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_quiet("rst_a");
    sel = 1'b1;
    #1;
    chk_quiet("rst_b");
    reset = 1'b1;
    @(posedge clk);

    run_frame(1'b0, 1, -1, 0, 3, 1'b0, -1);
    run_frame(1'b0, 0, 10, 3, 0, 1'b1, -1);
    run_frame(1'b0, 0, -1, 0, 2, 1'b0, 20);
    run_frame(1'b0, 0, -1, 0, 1, 1'b0, -1);
    run_frame(1'b1, 1, -1, 0, 0, 1'b0, -1);
    for (int r = 0; r < 6; r++) begin
      run_frame(1'b1, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), 1'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
